// File: rtl/decoder_nto2n_seq_if.sv
// Control/select bus between a controller and decoder_nto2n_seq.
//   en, mode, in_valid, in : controller -> decoder (enable, scan select, index)
//   out, out_valid, addr   : decoder -> consumer (select lines, valid, index)
//   wrap                   : decoder -> consumer (end-of-sweep pulse)
interface decoder_nto2n_seq_if #(
  parameter int unsigned IN_W = 2
);
  localparam int unsigned OUT_W = 1 << IN_W;

  logic             en;
  logic             mode;
  logic             in_valid;
  logic [IN_W-1:0]  in;
  logic [OUT_W-1:0] out;
  logic             out_valid;
  logic [IN_W-1:0]  addr;
  logic             wrap;

  modport master (
    output en, mode, in_valid, in,
    input  out, out_valid, addr, wrap
  );

  modport slave (
    input  en, mode, in_valid, in,
    output out, out_valid, addr, wrap
  );
endinterface

// File: rtl/decoder_nto2n_seq.sv
// Registered N-to-2^N one-hot decoder with enable, optional active-low
// outputs and an autonomous scan mode that walks the active line.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   dec  : slave side of decoder_nto2n_seq_if
//          (en, mode, in_valid, in in; out, out_valid, addr, wrap out)
module decoder_nto2n_seq #(
  parameter int unsigned IN_W       = 2,
  parameter bit          ACTIVE_LOW = 1'b0,
  parameter int unsigned SCAN_DIV   = 4
) (
  input logic            clk,
  input logic            rst,
  decoder_nto2n_seq_if.slave dec
);
  localparam int unsigned OUT_W = 1 << IN_W;
  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [IN_W-1:0]  ADDR_LAST = '1;
  // XOR mask that turns an active-high pattern into the configured polarity.
  localparam logic [OUT_W-1:0] OUT_POL   = ACTIVE_LOW ? '1 : '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_SCAN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IN_W-1:0]  addr_q, addr_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;
  logic [OUT_W-1:0] out_q, out_d;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: en=0 dominates, then mode.
  always_comb begin
    state_d = state_q;
    if (!dec.en) begin
      state_d = ST_IDLE;
    end else if (dec.mode) begin
      state_d = ST_SCAN;
    end else if (dec.in_valid) begin
      state_d = ST_HOLD;
    end else if (state_q != ST_HOLD) begin
      state_d = ST_IDLE;
    end
  end

  // Next values for the registered outputs and scan divider.
  always_comb begin
    addr_d  = addr_q;
    div_d   = div_q;
    valid_d = valid_q;
    wrap_d  = 1'b0;
    if (!dec.en) begin
      valid_d = 1'b0;
      div_d   = '0;
    end else if (dec.mode) begin
      if (state_q != ST_SCAN) begin
        addr_d  = '0;
        div_d   = '0;
        valid_d = 1'b1;
      end else if (div_q == DIV_LAST) begin
        div_d  = '0;
        addr_d = addr_q + IN_W'(1);
        wrap_d = (addr_q == ADDR_LAST);
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end else if (dec.in_valid) begin
      addr_d  = dec.in;
      div_d   = '0;
      valid_d = 1'b1;
    end else if (state_q != ST_HOLD) begin
      // Leaving scan (or idling) without a new index drops the line.
      valid_d = 1'b0;
      div_d   = '0;
    end
    out_d = (valid_d ? (OUT_W'(1) << addr_d) : OUT_W'(0)) ^ OUT_POL;
  end

  // Output and divider registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      div_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      out_q   <= OUT_POL;
    end else begin
      addr_q  <= addr_d;
      div_q   <= div_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      out_q   <= out_d;
    end
  end

  assign dec.out       = out_q;
  assign dec.out_valid = valid_q;
  assign dec.addr      = addr_q;
  assign dec.wrap      = wrap_q;
endmodule

// File: doc/decoder_nto2n_seq.md
# decoder_nto2n_seq

- Parametrised, registered N-to-2^N one-hot decoder that generalises the team's 2-to-4 combinational decoder.
- Adds a clocked output stage, an enable, and optional active-low outputs.
- Adds an autonomous scan mode that walks the one-hot output across all lines at a programmable rate, for strobe and row-select duty in display and demux paths.
- Sits between a control FSM, or a free-running timer, and the select lines it drives.

## Interface
- IN_W, 2, width of the index input; output width is 2**IN_W (IN_W ≥ 1).
- ACTIVE_LOW, 0, 1 inverts every bit of `out` (active line 0, inactive lines 1).
- SCAN_DIV, 4, clock cycles each line stays active in scan mode (≥ 1).

Ports:
- clk  in  1  rising-edge clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- en  in  1  1 enables decoding; 0 forces outputs inactive.
- mode  in  1  0 selects direct decode; 1 selects scan.
- in_valid  in  1  qualifies `in` in direct mode; ignored in scan mode.
- in  in  IN_W  index to decode.
- out  out  2**IN_W  registered one-hot output (polarity set by ACTIVE_LOW).
- out_valid  out  1  1 when `out` holds an active line.
- addr  out  IN_W  index currently decoded onto `out`.
- wrap  out  1  one-cycle pulse when scan steps from 2**IN_W−1 to 0.

## Operation
- States: IDLE, HOLD, SCAN. Reset enters IDLE.
- Reset values:
  - `out` is all-inactive: 0s, or all 1s when ACTIVE_LOW=1.
  - `out_valid` = 0, `addr` = 0, `wrap` = 0, divider count = 0.
- Priority each cycle: rst > en=0 > mode.
- en=0, from any state:
  - Next state IDLE.
  - `out` all-inactive, `out_valid` = 0, `wrap` = 0, divider cleared.
  - `addr` retains its last value.
- Direct (mode=0, en=1):
  - in_valid=1 → `addr` ← `in`, `out` ← onehot(`in`), `out_valid` ← 1, next state HOLD.
  - in_valid=0 in HOLD → outputs hold.
  - in_valid=0 in IDLE → stays IDLE.
  - Back-to-back in_valid updates every cycle.
- Scan entry (mode=1, en=1, state ≠ SCAN):
  - `addr` ← 0, `out` ← onehot(0), `out_valid` ← 1, divider ← 0, next state SCAN.
  - `in` and `in_valid` are ignored.
- In SCAN, each cycle:
  - If divider = SCAN_DIV−1: divider ← 0 and `addr` ← `addr`+1, modulo 2**IN_W.
  - Otherwise: divider ← divider+1.
  - `out` always equals onehot(`addr`).
- Wrap-around:
  - `wrap` = 1 for exactly the cycle in which `addr` becomes 0 from 2**IN_W−1.
  - `wrap` = 0 on scan entry.
- SCAN → mode=0:
  - With in_valid=1 the same cycle: HOLD with `in` decoded.
  - Otherwise: IDLE, outputs inactive, `out_valid` = 0.
- SCAN_DIV=1: `addr` advances every cycle.
- ACTIVE_LOW affects only `out`. `out_valid` and `wrap` stay active-high.

## Timing
- Every output is registered; nothing is combinational from input to output.
- Direct latency: 1 cycle from a sampled `in`/`in_valid` to `out`/`out_valid`/`addr`.
- Scan start:
  - Line 0 is active from the first edge after mode=1 & en=1 is sampled.
  - Each line stays active for exactly SCAN_DIV cycles.
  - Full sweep takes 2**IN_W × SCAN_DIV cycles.
- en=0, rst, or an exit from scan to IDLE: outputs inactive on the next edge.
- Mid-scan reset or disable discards scan position. Re-entry always restarts at line 0.
- `out` is never multi-hot. `out` is never all-inactive while `out_valid`=1.

## Test plan
- Reset, IN_W=2, ACTIVE_LOW=0: assert rst 2 cycles → `out`=0000, `out_valid`=0, `addr`=00, `wrap`=0.
- Direct sweep, en=1, mode=0: `in`=00,01,10,11 with in_valid each cycle → `out` = 0001, 0010, 0100, 1000, each one cycle later; in_valid=0 afterwards → 1000 holds.
- Scan, SCAN_DIV=3:
  - Raise mode=1 → `addr` reads 0,0,0,1,1,1,2,2,2,3,3,3,0.
  - `wrap`=1 only on the cycle `addr` returns to 0.
- Disable mid-scan: en=0 while `addr`=2 → next cycle `out`=0000, `out_valid`=0; en=1 again → scan restarts at `out`=0001.
- ACTIVE_LOW=1, IN_W=3: direct `in`=101 → `out`=11011111; reset → `out`=11111111.
- Simultaneous events: rst=1 with en=1, in_valid=1 → reset wins. SCAN → mode=0 with in_valid=1, `in`=10 → `out`=0100 next cycle.
